nibble_serial_adder: RTL and testbench
======================================

Name: nibble_serial_adder

Overview:
- Multi-cycle adder-subtracter for WIDTH = 4*NIBBLES operand words.
- Reuses one four-bit adder slice (fba) across successive cycles.
- Sits directly around the slice:
  - upstream, it captures the operands and drives A, B and C one nibble per cycle, LSB first;
  - downstream, it consumes SUM and CARRY, registers the result and chains the carry.
- Serves as the SAP accumulator/B-register adder-subtracter path for widths above 4 bits.

Parameters:
- NIBBLES, 2, number of 4-bit slices per word (WIDTH = 4*NIBBLES; minimum 1).

Ports:
- CLK  input  1  system clock; all state changes on rising edge.
- CLR_N  input  1  asynchronous active-low reset.
- START  input  1  request an operation; sampled only when BUSY=0.
- SUB  input  1  0 = A+B, 1 = A-B (two's complement); captured with START.
- A_IN  input  WIDTH  operand A; captured with START.
- B_IN  input  WIDTH  operand B; captured with START.
- BUSY  output  1  high while slices are being processed.
- DONE  output  1  one-cycle pulse; result/flags valid from this cycle.
- RESULT  output  WIDTH  registered sum/difference.
- COUT  output  1  final carry out (for SUB: 1 = no borrow).
- OVF  output  1  signed two's-complement overflow.
- ZERO  output  1  RESULT == 0.

Behaviour:
- Reset (CLR_N=0, asynchronous): state IDLE; nibble index 0; carry register 0; operand registers 0. Outputs BUSY=0, DONE=0, RESULT=0, COUT=0, OVF=0, ZERO=0.
- FSM states: IDLE, RUN, FIN.
  - IDLE: START=1 at edge k captures A_IN, SUB, and B_IN (B_IN inverted when SUB=1). Carry register loads SUB; index loads 0. Goes to RUN.
  - RUN: BUSY=1. Each cycle drives the slice with A nibble[idx], B' nibble[idx] and the carry register. At the edge, SUM is written to RESULT nibble[idx], CARRY goes to the carry register, and idx increments. When idx = NIBBLES-1, goes to FIN instead of incrementing.
  - FIN: DONE=1, BUSY=0 for exactly one cycle. COUT, OVF and ZERO are valid. START=1 here is accepted exactly as in IDLE (back-to-back operation); otherwise goes to IDLE.
- Latency:
  - START sampled at edge k gives BUSY=1 during cycles k+1 .. k+NIBBLES.
  - DONE=1 during cycle k+NIBBLES+1.
  - Throughput: one operation per NIBBLES+1 cycles.
- Register behaviour:
  - RESULT, COUT, OVF and ZERO hold their values after FIN until the next result write.
  - RESULT nibbles update progressively during RUN; they are only architecturally valid when DONE=1 or in IDLE afterwards.
  - COUT, OVF and ZERO are registered on the last RUN edge. They are not updated in intermediate RUN cycles.
- OVF is computed as (A[WIDTH-1] == B'[WIDTH-1]) && (RESULT[WIDTH-1] != A[WIDTH-1]), where B' is the effective (possibly inverted) operand.
- Input handling:
  - START while BUSY=1 is ignored: no capture, no queueing.
  - A_IN, B_IN and SUB changes during RUN have no effect.
- Width and wrap: RESULT wraps modulo 2^WIDTH; the carry beyond the MSB is only in COUT.
- Reset asserted mid-RUN aborts the operation immediately to reset values. No DONE is produced for the aborted operation.
- NIBBLES=1: RUN lasts one cycle, then FIN.

Decomposition:
- sap_pkg holds:
  - the NIBBLE_W = 4 constant;
  - the typedef enum logic [1:0] {IDLE, RUN, FIN} add_state_t;
  - the helper function for the idx width, $clog2 of NIBBLES with minimum 1.
- One sub-module: fba, the existing four-bit adder (A, B, C, SUM, CARRY), instantiated once.
- Operand nibble select, carry register and FSM stay in nibble_serial_adder.

Test Plan (NIBBLES=2):
- Add: START, SUB=0, A=8'h3C, B=8'h05 -> BUSY=1 for 2 cycles, then DONE pulse; RESULT=8'h41, COUT=0, OVF=0, ZERO=0.
- Wrap: A=8'hFF, B=8'h01, SUB=0 -> RESULT=8'h00, COUT=1, ZERO=1, OVF=0.
- Signed overflow: A=8'h7F, B=8'h01, SUB=0 -> RESULT=8'h80, OVF=1, COUT=0.
- Subtract / borrow:
  - A=8'h10, B=8'h01, SUB=1 -> RESULT=8'h0F, COUT=1.
  - Then, with START held during FIN, A=8'h00, B=8'h01, SUB=1 -> RESULT=8'hFF, COUT=0, OVF=0, second DONE exactly 3 cycles after the first.
- START during BUSY: pulse START with A=8'h55, B=8'h11 in the first RUN cycle of a 8'h3C+8'h05 operation -> ignored; RESULT=8'h41, single DONE.
- Reset mid-RUN: assert CLR_N=0 during the second RUN cycle -> all outputs 0 immediately. After release, no DONE until a new START; a new 8'h01+8'h02 gives RESULT=8'h03.

Source files
------------

// File: rtl/sap_pkg.sv
// Shared constants and types for the SAP multi-nibble adder-subtracter path.
package sap_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {IDLE, RUN, FIN} add_state_t;

    // Width of the nibble index; never narrower than one bit.
    function automatic int idx_w(input int nibbles);
        return (nibbles <= 1) ? 1 : $clog2(nibbles);
    endfunction

endpackage

// File: rtl/fba.sv
// Four-bit adder slice: SUM/CARRY = A + B + C.
module fba (
    input  logic [3:0] A,
    input  logic [3:0] B,
    input  logic       C,
    output logic [3:0] SUM,
    output logic       CARRY
);

    logic [4:0] total;

    always_comb begin
        total = {1'b0, A} + {1'b0, B} + {4'b0000, C};
    end

    assign SUM   = total[3:0];
    assign CARRY = total[4];

endmodule

// File: rtl/nibble_serial_adder.sv
// Multi-cycle adder-subtracter that streams operands LSB-nibble first
// through a single fba slice, chaining the carry between cycles.
module nibble_serial_adder
    import sap_pkg::*;
#(
    parameter int NIBBLES = 2
) (
    input  logic                          CLK,
    input  logic                          CLR_N,
    input  logic                          START,
    input  logic                          SUB,
    input  logic [NIBBLE_W*NIBBLES-1:0]   A_IN,
    input  logic [NIBBLE_W*NIBBLES-1:0]   B_IN,
    output logic                          BUSY,
    output logic                          DONE,
    output logic [NIBBLE_W*NIBBLES-1:0]   RESULT,
    output logic                          COUT,
    output logic                          OVF,
    output logic                          ZERO
);

    localparam int WIDTH = NIBBLE_W * NIBBLES;
    localparam int IW    = idx_w(NIBBLES);

    add_state_t          state;
    logic [IW-1:0]       idx;
    logic                carry;
    logic [WIDTH-1:0]    a_q;
    logic [WIDTH-1:0]    b_q;

    logic [NIBBLE_W-1:0] a_nib;
    logic [NIBBLE_W-1:0] b_nib;
    logic [NIBBLE_W-1:0] sum;
    logic                cy;
    logic [WIDTH-1:0]    res_next;
    logic                last;

    always_comb begin
        a_nib    = a_q[NIBBLE_W*idx +: NIBBLE_W];
        b_nib    = b_q[NIBBLE_W*idx +: NIBBLE_W];
        res_next = RESULT;
        res_next[NIBBLE_W*idx +: NIBBLE_W] = sum;
        last     = (idx == IW'(NIBBLES - 1));
    end

    fba u_fba (
        .A     (a_nib),
        .B     (b_nib),
        .C     (carry),
        .SUM   (sum),
        .CARRY (cy)
    );

    always_ff @(posedge CLK or negedge CLR_N) begin
        if (!CLR_N) begin
            state  <= IDLE;
            idx    <= '0;
            carry  <= 1'b0;
            a_q    <= '0;
            b_q    <= '0;
            BUSY   <= 1'b0;
            DONE   <= 1'b0;
            RESULT <= '0;
            COUT   <= 1'b0;
            OVF    <= 1'b0;
            ZERO   <= 1'b0;
        end else begin
            case (state)
                IDLE, FIN: begin
                    DONE <= 1'b0;
                    if (START) begin
                        // B is pre-inverted and carry-in set so subtraction is A + ~B + 1.
                        a_q   <= A_IN;
                        b_q   <= SUB ? ~B_IN : B_IN;
                        carry <= SUB;
                        idx   <= '0;
                        BUSY  <= 1'b1;
                        state <= RUN;
                    end else begin
                        BUSY  <= 1'b0;
                        state <= IDLE;
                    end
                end
                RUN: begin
                    RESULT <= res_next;
                    carry  <= cy;
                    if (last) begin
                        COUT  <= cy;
                        OVF   <= (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                                 (res_next[WIDTH-1] != a_q[WIDTH-1]);
                        ZERO  <= (res_next == '0);
                        BUSY  <= 1'b0;
                        DONE  <= 1'b1;
                        state <= FIN;
                    end else begin
                        idx   <= idx + 1'b1;
                    end
                end
                default: begin
                    BUSY  <= 1'b0;
                    DONE  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Directed self-checking bench for nibble_serial_adder with NIBBLES=2.
module tb_nibble_serial_adder;

    logic       CLK = 1'b0;
    logic       CLR_N = 1'b0;
    logic       START = 1'b0;
    logic       SUB = 1'b0;
    logic [7:0] A_IN = '0;
    logic [7:0] B_IN = '0;
    logic       BUSY;
    logic       DONE;
    logic [7:0] RESULT;
    logic       COUT;
    logic       OVF;
    logic       ZERO;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    nibble_serial_adder #(.NIBBLES(2)) dut (
        .CLK    (CLK),
        .CLR_N  (CLR_N),
        .START  (START),
        .SUB    (SUB),
        .A_IN   (A_IN),
        .B_IN   (B_IN),
        .BUSY   (BUSY),
        .DONE   (DONE),
        .RESULT (RESULT),
        .COUT   (COUT),
        .OVF    (OVF),
        .ZERO   (ZERO)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"},   BUSY,   0);
        check({tag, "_done"},   DONE,   0);
        check({tag, "_result"}, RESULT, 0);
        check({tag, "_cout"},   COUT,   0);
        check({tag, "_ovf"},    OVF,    0);
        check({tag, "_zero"},   ZERO,   0);
    endtask

    // Issue one operation and wait (bounded) for DONE; checks latency and results.
    task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                          input logic sub, input logic [7:0] er, input logic ec,
                          input logic eo, input logic ez);
        int busy_n = 0;
        int waited = 0;
        @(negedge CLK);
        START = 1'b1; A_IN = a; B_IN = b; SUB = sub;
        @(negedge CLK);
        START = 1'b0;
        while (!DONE && waited < 8) begin
            busy_n += int'(BUSY);
            @(negedge CLK);
            waited++;
        end
        check({tag, "_done"},   DONE,   1);
        check({tag, "_busyn"},  busy_n, 2);
        check({tag, "_busy0"},  BUSY,   0);
        check({tag, "_result"}, RESULT, er);
        check({tag, "_cout"},   COUT,   ec);
        check({tag, "_ovf"},    OVF,    eo);
        check({tag, "_zero"},   ZERO,   ez);
        @(negedge CLK);
        check({tag, "_pulse"},  DONE,   0);
        check({tag, "_hold"},   RESULT, er);
    endtask

    task automatic count_dones(input int cycles, output int n);
        n = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge CLK);
            n += int'(DONE);
        end
    endtask

    initial begin
        int n;

        @(negedge CLK);
        check_all_zero("reset");
        @(negedge CLK);
        CLR_N = 1'b1;
        @(negedge CLK);
        check_all_zero("idle");

        run_op("add",  8'h3C, 8'h05, 1'b0, 8'h41, 1'b0, 1'b0, 1'b0);
        run_op("wrap", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
        run_op("ovf",  8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, 1'b0);

        // Back-to-back subtraction: second START held during the first DONE cycle.
        @(negedge CLK);
        START = 1'b1; A_IN = 8'h10; B_IN = 8'h01; SUB = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        check("sub1_busy1", BUSY, 1);
        @(negedge CLK);
        check("sub1_busy2", BUSY, 1);
        @(negedge CLK);
        check("sub1_done",   DONE,   1);
        check("sub1_result", RESULT, 8'h0F);
        check("sub1_cout",   COUT,   1);
        START = 1'b1; A_IN = 8'h00; B_IN = 8'h01; SUB = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        check("sub2_busy1", BUSY, 1);
        check("sub2_nodone", DONE, 0);
        @(negedge CLK);
        check("sub2_busy2", BUSY, 1);
        @(negedge CLK);
        check("sub2_done",   DONE,   1);
        check("sub2_result", RESULT, 8'hFF);
        check("sub2_cout",   COUT,   0);
        check("sub2_ovf",    OVF,    0);
        check("sub2_zero",   ZERO,   0);
        @(negedge CLK);
        SUB = 1'b0;

        // START with new operands during the first RUN cycle must be ignored.
        @(negedge CLK);
        START = 1'b1; A_IN = 8'h3C; B_IN = 8'h05; SUB = 1'b0;
        @(negedge CLK);
        check("ign_busy", BUSY, 1);
        A_IN = 8'h55; B_IN = 8'h11;
        @(negedge CLK);
        START = 1'b0;
        check("ign_busy2", BUSY, 1);
        @(negedge CLK);
        check("ign_done",   DONE,   1);
        check("ign_result", RESULT, 8'h41);
        count_dones(6, n);
        check("ign_single", n, 0);

        // Reset asserted in the second RUN cycle aborts the operation.
        @(negedge CLK);
        START = 1'b1; A_IN = 8'h3C; B_IN = 8'h05; SUB = 1'b0;
        @(negedge CLK);
        START = 1'b0;
        @(negedge CLK);
        check("abort_busy", BUSY, 1);
        CLR_N = 1'b0;
        #1;
        check_all_zero("abort");
        @(negedge CLK);
        CLR_N = 1'b1;
        count_dones(5, n);
        check("abort_nodone", n, 0);
        check("abort_idle_result", RESULT, 0);
        run_op("post", 8'h01, 8'h02, 1'b0, 8'h03, 1'b0, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
